// File: rtl/fifo_rd_ptr_ctl_if.sv
// Read-side port bundle of the dual-clock FIFO: pop request, synchronized write
// pointer, error clear in; RAM address, Gray read pointer, flags and count out.
interface fifo_rd_ptr_ctl_if #(
  parameter int unsigned ASIZE = 4
);
  logic             rinc;
  logic [ASIZE:0]   rq2_wptr;
  logic             rerr_clr;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   rptr;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   rcount;
  logic             rerr_underflow;

  // Consumer / synchronizer side
  modport master (
    output rinc, rq2_wptr, rerr_clr,
    input  raddr, rptr, rempty, ralmost_empty, rcount, rerr_underflow
  );

  // Pointer controller side
  modport slave (
    input  rinc, rq2_wptr, rerr_clr,
    output raddr, rptr, rempty, ralmost_empty, rcount, rerr_underflow
  );
endinterface

// File: rtl/fifo_rd_ptr_ctl.sv
// Read-side pointer/flag controller of the dual-clock FIFO (rclk domain):
// binary+Gray read pointer, empty/almost-empty flags, fill count, sticky underflow.
module fifo_rd_ptr_ctl #(
  parameter int unsigned ASIZE    = 4,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic             rclk,
  input logic             rrst_n,
  fifo_rd_ptr_ctl_if.slave rif
);
  localparam int unsigned PW = ASIZE + 1;

  logic [PW-1:0] rbin_q;
  logic [PW-1:0] rptr_q;
  logic          rempty_q;
  logic          ralmost_empty_q;
  logic [PW-1:0] rcount_q;
  logic          rerr_q;

  logic          pop_c;
  logic [PW-1:0] rbinnext_c;
  logic [PW-1:0] rgraynext_c;
  logic [PW-1:0] wbin_c;
  logic [PW-1:0] fill_c;

  // Next pointer, Gray-decoded write pointer and the resulting fill level
  always_comb begin
    pop_c       = rif.rinc & ~rempty_q;
    rbinnext_c  = rbin_q + PW'(pop_c);
    rgraynext_c = (rbinnext_c >> 1) ^ rbinnext_c;
    wbin_c      = '0;
    for (int i = 0; i < PW; i++) begin
      wbin_c[i] = ^(rif.rq2_wptr >> i);
    end
    fill_c      = wbin_c - rbinnext_c;
  end

  // Flags are computed from the post-pop pointer so they agree with rempty
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q          <= '0;
      rptr_q          <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rcount_q        <= '0;
      rerr_q          <= 1'b0;
    end else begin
      rbin_q          <= rbinnext_c;
      rptr_q          <= rgraynext_c;
      rempty_q        <= (rgraynext_c == rif.rq2_wptr);
      rcount_q        <= fill_c;
      ralmost_empty_q <= (fill_c <= PW'(AE_LEVEL));
      if (rif.rinc && rempty_q) begin
        rerr_q <= 1'b1;
      end else if (rif.rerr_clr) begin
        rerr_q <= 1'b0;
      end
    end
  end

  assign rif.raddr          = rbin_q[ASIZE-1:0];
  assign rif.rptr           = rptr_q;
  assign rif.rempty         = rempty_q;
  assign rif.ralmost_empty  = ralmost_empty_q;
  assign rif.rcount         = rcount_q;
  assign rif.rerr_underflow = rerr_q;
endmodule

// File: tb/tb_fifo_rd_ptr_ctl.sv
// Bench for fifo_rd_ptr_ctl: directed scenarios then random traffic, checked
// against an occupancy model built from total words written and read.
module tb_fifo_rd_ptr_ctl;
  localparam int unsigned ASIZE = 4;
  localparam int          DEPTH = 16;
  localparam int          AE    = 2;

  logic rclk = 1'b0;
  logic rrst_n = 1'b1;
  always #5 rclk = ~rclk;

  fifo_rd_ptr_ctl_if #(.ASIZE(ASIZE)) rif ();

  fifo_rd_ptr_ctl #(.ASIZE(ASIZE), .AE_LEVEL(AE)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rif    (rif)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: unbounded totals of words written/read; everything derives from them
  int w_tot, rd_tot;
  bit m_empty, m_err;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b % 32);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    int occ;
    occ = w_tot - rd_tot;
    check({where, " rempty"},  32'(rif.rempty),         32'(m_empty));
    check({where, " rcount"},  32'(rif.rcount),         32'(occ));
    check({where, " ralmost"}, 32'(rif.ralmost_empty),  32'(occ <= AE));
    check({where, " rptr"},    32'(rif.rptr),           32'(gray5(rd_tot)));
    check({where, " raddr"},   32'(rif.raddr),          32'(rd_tot % DEPTH));
    check({where, " rerr"},    32'(rif.rerr_underflow), 32'(m_err));
  endtask

  // One rclk: apply inputs, advance model on the edge, check 1 time unit later
  task automatic step(input bit inc, input bit clr, input int wadd);
    logic [4:0] prev_rptr;
    bit pop;
    w_tot += wadd;
    rif.rinc     = inc;
    rif.rerr_clr = clr;
    rif.rq2_wptr = gray5(w_tot);
    prev_rptr    = rif.rptr;
    @(posedge rclk);
    pop = inc && !m_empty;
    if (pop) rd_tot++;
    if (inc && m_empty) m_err = 1'b1;
    else if (clr)       m_err = 1'b0;
    m_empty = (w_tot == rd_tot);
    #1;
    check_all("step");
    if (pop) check("gray_1bit", 32'($countones(rif.rptr ^ prev_rptr)), 32'd1);
  endtask

  // Asynchronous reset asserted mid-cycle, released away from the edge
  task automatic do_reset();
    #2;
    rrst_n       = 1'b0;
    rif.rinc     = 1'b0;
    rif.rerr_clr = 1'b0;
    rif.rq2_wptr = '0;
    w_tot = 0; rd_tot = 0; m_empty = 1'b1; m_err = 1'b0;
    #1;
    check_all("reset");
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  initial begin
    int occ, wadd;
    bit inc, clr;
    rif.rinc = 1'b0; rif.rerr_clr = 1'b0; rif.rq2_wptr = '0;
    w_tot = 0; rd_tot = 0; m_empty = 1'b1; m_err = 1'b0;

    // Reset state
    do_reset();
    check("rst rempty", 32'(rif.rempty), 32'd1);
    check("rst ralmost", 32'(rif.ralmost_empty), 32'd1);
    check("rst rcount", 32'(rif.rcount), 32'd0);

    // First word arrives, then is popped
    step(1'b0, 1'b0, 1);
    check("arrive rempty", 32'(rif.rempty), 32'd0);
    check("arrive rcount", 32'(rif.rcount), 32'd1);
    step(1'b1, 1'b0, 0);
    check("pop1 rempty", 32'(rif.rempty), 32'd1);
    check("pop1 rptr", 32'(rif.rptr), 32'd1);
    check("pop1 raddr", 32'(rif.raddr), 32'd1);
    check("pop1 rcount", 32'(rif.rcount), 32'd0);

    // Almost-empty threshold
    do_reset();
    step(1'b0, 1'b0, 3);
    check("ae3 rcount", 32'(rif.rcount), 32'd3);
    check("ae3 ralmost", 32'(rif.ralmost_empty), 32'd0);
    step(1'b1, 1'b0, 0);
    check("ae2 rcount", 32'(rif.rcount), 32'd2);
    check("ae2 ralmost", 32'(rif.ralmost_empty), 32'd1);

    // Full depth then drain
    do_reset();
    step(1'b0, 1'b0, 16);
    check("full rcount", 32'(rif.rcount), 32'd16);
    check("full rempty", 32'(rif.rempty), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 0);
    check("drain rempty", 32'(rif.rempty), 32'd1);
    check("drain raddr", 32'(rif.raddr), 32'd0);

    // Simultaneous write/read across the pointer wrap
    step(1'b0, 1'b0, 1);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 1);
      check("pair rcount", 32'(rif.rcount), 32'd1);
    end
    step(1'b1, 1'b0, 0);

    // Underflow: set, set-wins-over-clear, clear
    step(1'b1, 1'b0, 0);
    check("uf set", 32'(rif.rerr_underflow), 32'd1);
    step(1'b1, 1'b1, 0);
    check("uf set_wins", 32'(rif.rerr_underflow), 32'd1);
    step(1'b0, 1'b1, 0);
    check("uf clear", 32'(rif.rerr_underflow), 32'd0);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      occ  = w_tot - rd_tot;
      wadd = int'($urandom_range(0, 2));
      if (wadd > DEPTH - occ) wadd = DEPTH - occ;
      inc  = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      clr  = ($urandom_range(0, 7) == 0);
      if (i == 250) do_reset();
      step(inc, clr, wadd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
